// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronise, debounce, edge pulses,
// long-press detection and a wrapping press counter for the jump button.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned LONG_PRESS_CYCLES = 12500000,
  parameter int unsigned CNT_W             = 24
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       jump_raw,
  input  logic       halt_raw,
  output logic       jump_out,
  output logic       jump_rise,
  output logic       jump_fall,
  output logic       jump_long,
  output logic       halt_out,
  output logic [7:0] press_count
);

  localparam int unsigned NCH  = 2;
  localparam int unsigned JUMP = 0;
  localparam int unsigned HALT = 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } state_t;

  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   r_sync1;
  logic [NCH-1:0]   r_sync2;
  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CNT_W-1:0] r_cnt       [NCH];
  logic [CNT_W-1:0] w_cnt_nxt   [NCH];
  logic [NCH-1:0]   r_level;
  logic [NCH-1:0]   w_level_nxt;

  logic             r_jump_rise;
  logic             r_jump_fall;
  logic             r_jump_long;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [7:0]       r_press;

  assign w_raw = {halt_raw, jump_raw};

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        r_state[ch] <= STABLE_LO;
        r_cnt[ch]   <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
    end
  end

  // The accepted level only changes on a CHECK_* exit, so edge pulses are
  // derived from the next-level transition rather than from the FSM states.
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
      w_level_nxt[ch] = r_level[ch];
      unique case (r_state[ch])
        STABLE_LO: begin
          if (r_sync2[ch]) begin
            w_state_nxt[ch] = CHECK_HI;
            w_cnt_nxt[ch]   = '0;
          end
        end
        CHECK_HI: begin
          if (!r_sync2[ch]) begin
            w_state_nxt[ch] = STABLE_LO;
          end else if (r_cnt[ch] == DB_LAST) begin
            w_state_nxt[ch] = STABLE_HI;
            w_level_nxt[ch] = 1'b1;
          end else begin
            w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!r_sync2[ch]) begin
            w_state_nxt[ch] = CHECK_LO;
            w_cnt_nxt[ch]   = '0;
          end
        end
        CHECK_LO: begin
          if (r_sync2[ch]) begin
            w_state_nxt[ch] = STABLE_HI;
          end else if (r_cnt[ch] == DB_LAST) begin
            w_state_nxt[ch] = STABLE_LO;
            w_level_nxt[ch] = 1'b0;
          end else begin
            w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[ch] = STABLE_LO;
        end
      endcase
    end
  end

  always_comb begin
    w_hold_nxt = '0;
    if (r_level[JUMP]) begin
      w_hold_nxt = (r_hold == LP_MAX) ? r_hold : r_hold + CNT_W'(1);
    end
  end

  // Gating jump_long with the next level makes it drop together with jump_fall.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_jump_rise <= 1'b0;
      r_jump_fall <= 1'b0;
      r_jump_long <= 1'b0;
      r_hold      <= '0;
      r_press     <= '0;
    end else begin
      r_jump_rise <= w_level_nxt[JUMP] & ~r_level[JUMP];
      r_jump_fall <= ~w_level_nxt[JUMP] & r_level[JUMP];
      r_jump_long <= w_level_nxt[JUMP] & (w_hold_nxt == LP_MAX);
      r_hold      <= w_hold_nxt;
      if (r_jump_rise) begin
        r_press <= r_press + 8'd1;
      end
    end
  end

  assign jump_out    = r_level[JUMP];
  assign halt_out    = r_level[HALT];
  assign jump_rise   = r_jump_rise;
  assign jump_fall   = r_jump_fall;
  assign jump_long   = r_jump_long;
  assign press_count = r_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// bounce traffic, compared cycle by cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       jump_raw;
  logic       halt_raw;
  logic       jump_out;
  logic       jump_rise;
  logic       jump_fall;
  logic       jump_long;
  logic       halt_out;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .CNT_W            (24)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .jump_raw   (jump_raw),
    .halt_raw   (halt_raw),
    .jump_out   (jump_out),
    .jump_rise  (jump_rise),
    .jump_fall  (jump_fall),
    .jump_long  (jump_long),
    .halt_out   (halt_out),
    .press_count(press_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a level flips once D+1 consecutive synchronised samples
  // disagree with it; synchronised sample = raw seen two edges earlier.
  bit          q_j[$];
  bit          q_h[$];
  bit          m_lvl[2];
  int          m_run[2];
  int          edge_n;
  int          rise_total;
  int          rise_edge;
  logic [12:0] exp_vec;
  logic [12:0] obs;

  assign obs = {jump_out, jump_rise, jump_fall, jump_long, halt_out, press_count};

  task automatic model_reset();
    q_j.delete();
    q_h.delete();
    m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
    m_run[0] = 0;    m_run[1] = 0;
    edge_n = 0;
    rise_total = 0;
    rise_edge = 0;
  endtask

  task automatic model_chan(input int ch, input bit raw);
    bit s;
    s = 1'b0;
    if (ch == 0) begin
      q_j.push_back(raw);
      if (q_j.size() >= 3) s = q_j[q_j.size()-3];
      if (q_j.size() > 3) void'(q_j.pop_front());
    end else begin
      q_h.push_back(raw);
      if (q_h.size() >= 3) s = q_h[q_h.size()-3];
      if (q_h.size() > 3) void'(q_h.pop_front());
    end
    if (s != m_lvl[ch]) m_run[ch]++;
    else m_run[ch] = 0;
    if (m_run[ch] == int'(D) + 1) begin
      m_lvl[ch] = s;
      m_run[ch] = 0;
    end
  endtask

  task automatic step();
    bit rj, rh, prev, rise, fall, lng;
    rj = jump_raw;
    rh = halt_raw;
    @(posedge clk);
    edge_n++;
    prev = m_lvl[0];
    model_chan(0, rj);
    model_chan(1, rh);
    rise = !prev && m_lvl[0];
    fall = prev && !m_lvl[0];
    exp_vec[7:0] = 8'(rise_total);
    if (rise) begin
      rise_total++;
      rise_edge = edge_n;
    end
    lng = m_lvl[0] && (edge_n - rise_edge >= int'(L));
    exp_vec[12:8] = {m_lvl[0], rise, fall, lng, m_lvl[1]};
    #1;
  endtask

  task automatic apply_reset();
    #3;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    jump_raw = 1'b0;
    halt_raw = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    jump_raw  = 1'b1;
    halt_raw  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++; $display("FAIL reset_hold: got %b want %b", obs, 13'd0);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL reset_model edge %0d: got %b want %b", i, obs, exp_vec);
      end
      if (i == 6) begin
        n_cmp++;
        if (jump_out !== 1'b0) begin
          n_err++; $display("FAIL reset_early edge 6: jump_out got %b want 0", jump_out);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({jump_out, jump_rise, halt_out} !== 3'b111) begin
          n_err++; $display("FAIL reset_rise edge 7: got %b want 111", {jump_out, jump_rise, halt_out});
        end
      end
      if (i == 8) begin
        n_cmp++;
        if ({jump_rise, press_count} !== {1'b0, 8'd1}) begin
          n_err++; $display("FAIL reset_count edge 8: rise/count got %b/%0d want 0/1", jump_rise, press_count);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] p0;
    jump_raw = 1'b0;
    halt_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL glitch_settle step %0d: got %b want %b", i, obs, exp_vec);
      end
    end
    p0 = 8'(rise_total);
    for (int i = 0; i < 15; i++) begin
      jump_raw = (i < 3);
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL glitch_model step %0d: got %b want %b", i, obs, exp_vec);
      end
      n_cmp++;
      if ({jump_out, jump_rise, jump_fall, press_count} !== {3'b000, p0}) begin
        n_err++; $display("FAIL glitch_quiet step %0d: got %b want %b", i,
                          {jump_out, jump_rise, jump_fall, press_count}, {3'b000, p0});
      end
    end
  endtask

  task automatic test_clean_press();
    int r_at, l_at, f_at, n_long;
    bit long_at_fall;
    r_at = 0; l_at = 0; f_at = 0; n_long = 0; long_at_fall = 1'b1;
    jump_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL press_model step %0d: got %b want %b", i, obs, exp_vec);
      end
      if (jump_rise === 1'b1 && r_at == 0) r_at = i;
      if (jump_long === 1'b1 && l_at == 0) l_at = i;
      if (jump_long === 1'b1) n_long++;
    end
    jump_raw = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL release_model step %0d: got %b want %b", j, obs, exp_vec);
      end
      if (jump_fall === 1'b1 && f_at == 0) begin
        f_at = j;
        long_at_fall = jump_long;
      end
    end
    n_cmp++;
    if (r_at != 7) begin n_err++; $display("FAIL press_rise_edge: got %0d want 7", r_at); end
    n_cmp++;
    if (l_at != 17) begin n_err++; $display("FAIL press_long_edge: got %0d want 17", l_at); end
    n_cmp++;
    if (n_long != 24) begin n_err++; $display("FAIL press_long_len: got %0d want 24", n_long); end
    n_cmp++;
    if (f_at != 7) begin n_err++; $display("FAIL press_fall_edge: got %0d want 7", f_at); end
    n_cmp++;
    if (long_at_fall !== 1'b0) begin
      n_err++; $display("FAIL press_long_at_fall: got %b want 0", long_at_fall);
    end
  endtask

  task automatic test_bounce();
    int n_fall, fall_i;
    n_fall = 0; fall_i = -1;
    jump_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL bounce_hold step %0d: got %b want %b", i, obs, exp_vec);
      end
    end
    for (int i = 0; i < 18; i++) begin
      jump_raw = (i == 2 || i == 3);
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL bounce_model step %0d: got %b want %b", i, obs, exp_vec);
      end
      if (jump_fall === 1'b1) begin
        n_fall++;
        fall_i = i;
      end
    end
    n_cmp++;
    if (n_fall != 1) begin n_err++; $display("FAIL bounce_count: got %0d want 1", n_fall); end
    n_cmp++;
    if (fall_i != 10) begin n_err++; $display("FAIL bounce_edge: got %0d want 10", fall_i); end
  endtask

  task automatic test_wrap_and_async_reset();
    apply_reset();
    for (int p = 0; p < 259; p++) begin
      for (int i = 0; i < 16; i++) begin
        jump_raw = (i < 8);
        halt_raw = (p >= 256);
        step();
        n_cmp++;
        if (obs !== exp_vec) begin
          n_err++; $display("FAIL wrap_model press %0d step %0d: got %b want %b", p, i, obs, exp_vec);
        end
      end
      if (p == 255) begin
        n_cmp++;
        if (press_count !== 8'd0) begin
          n_err++; $display("FAIL wrap_count: got %0d want 0", press_count);
        end
      end
    end
    jump_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL async_pre step %0d: got %b want %b", i, obs, exp_vec);
      end
    end
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++; $display("FAIL async_clear: got %b want %b", obs, 13'd0);
    end
    repeat (2) @(posedge clk);
    jump_raw = 1'b0;
    halt_raw = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if ({obs, jump_rise, jump_fall} !== {exp_vec, 2'b00}) begin
        n_err++; $display("FAIL async_post step %0d: got %b want %b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_independence();
    int j_at, h_at, l_at;
    j_at = 0; h_at = 0; l_at = 0;
    jump_raw = 1'b1;
    halt_raw = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 12) halt_raw = 1'b0;
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL indep_model step %0d: got %b want %b", i, obs, exp_vec);
      end
      if (jump_out === 1'b1 && j_at == 0) j_at = i;
      if (halt_out === 1'b1 && h_at == 0) h_at = i;
      if (jump_long === 1'b1 && l_at == 0) l_at = i;
    end
    n_cmp++;
    if (j_at != 7 || h_at != 7) begin
      n_err++; $display("FAIL indep_rise: jump/halt got %0d/%0d want 7/7", j_at, h_at);
    end
    n_cmp++;
    if (l_at != 17) begin n_err++; $display("FAIL indep_long: got %0d want 17", l_at); end
    jump_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_random();
    int run_j, run_h;
    run_j = 0; run_h = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_j == 0) begin
        jump_raw = 1'($urandom_range(0, 1));
        run_j = int'($urandom_range(1, 12));
      end
      if (run_h == 0) begin
        halt_raw = 1'($urandom_range(0, 1));
        run_h = int'($urandom_range(1, 12));
      end
      run_j--;
      run_h--;
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL random_model step %0d: got %b want %b", i, obs, exp_vec);
      end
      n_cmp++;
      if ((jump_rise & jump_fall) !== 1'b0) begin
        n_err++; $display("FAIL random_rise_fall step %0d: both high", i);
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    jump_raw  = 1'b0;
    halt_raw  = 1'b0;
    model_reset();
    test_reset();
    test_glitch();
    test_clean_press();
    test_bounce();
    test_wrap_and_async_reset();
    test_independence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
